tlul_host_adapter: RTL and testbench



---
 rtl/tlul_host_adapter.sv | 187 ++++++++++++++++++
 tb/tb_tlul_host_adapter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_adapter.sv
// Single-outstanding req/gnt/rvalid initiator bridged onto a TL-UL host port,
// with a saturating D-channel timeout so a dead device cannot hang the master.
package tlul_pkg;
  localparam int unsigned TlAIW     = 8;
  localparam int unsigned TlDIW     = 1;
  localparam int unsigned TlAUserW  = 14;
  localparam int unsigned TlDUserW  = 14;
  localparam logic [TlAUserW-1:0] TL_A_USER_DEFAULT = '0;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [TlAIW-1:0]    a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic [TlAUserW-1:0] a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    logic [2:0]          d_opcode;
    logic [2:0]          d_param;
    logic [1:0]          d_size;
    logic [TlAIW-1:0]    d_source;
    logic [TlDIW-1:0]    d_sink;
    logic [31:0]         d_data;
    logic [TlDUserW-1:0] d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned      TimeoutCycles = 1024,
  parameter logic [TlAIW-1:0] SourceId      = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [15:0] CntLast   = 16'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StASend, StDWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt;
  logic        d_match;

  assign d_match = tl_i.d_valid && (tl_i.d_source == SourceId);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    gnt      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          gnt     = 1'b1;
          we_d    = we_i;
          addr_d  = addr_i[31:2];
          wdata_d = wdata_i;
          be_d    = be_i;
          // A write with no enabled bytes completes locally without touching the bus.
          if (we_i && (be_i == 4'h0)) begin
            rvalid_d = 1'b1;
            err_d    = 1'b0;
          end else begin
            state_d = StASend;
          end
        end
      end
      StASend: begin
        if (tl_i.a_ready) begin
          state_d = StDWait;
          cnt_d   = '0;
        end
      end
      StDWait: begin
        if (d_match) begin
          rvalid_d = 1'b1;
          err_d    = tl_i.d_error;
          if (!we_q) rdata_d = tl_i.d_data;
          state_d = StIdle;
        end else begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (TimeoutEn && (cnt_q == CntLast)) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            state_d  = StDrain;
          end
        end
      end
      StDrain: begin
        // The late response must still be consumed so the device is not left stalled.
        if (d_match) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == StASend);
    tl_o.a_opcode  = !we_q ? Get : ((be_q == 4'hF) ? PutFullData : PutPartialData);
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = {addr_q, 2'b00};
    tl_o.a_mask    = we_q ? be_q : 4'hF;
    tl_o.a_data    = we_q ? wdata_q : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = (state_q == StDWait) || (state_q == StDrain);
  end

  assign gnt_o    = gnt & ~rst_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != StIdle);

  logic unused_tl_d;
  assign unused_tl_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench: default-timeout instance (a) for the main paths, a
// TimeoutCycles=4 instance (b) for timeout/drain behaviour; both share the D channel.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  tl_d2h_t     tl_d;
  tl_h2d_t     tl_a_o, tl_b_o;
  logic        gnt_a, rvalid_a, err_a, busy_a;
  logic        gnt_b, rvalid_b, err_b, busy_b;
  logic [31:0] rdata_a, rdata_b;

  int total = 0;
  int bad = 0;

  tlul_host_adapter u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .busy_o(busy_a), .tl_o(tl_a_o), .tl_i(tl_d)
  );

  tlul_host_adapter #(.TimeoutCycles(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .busy_o(busy_b), .tl_o(tl_b_o), .tl_i(tl_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; tl_d = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    req_a = 1'b1; req_b = 1'b1;
    tick(); tick(); smp();
    total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL rst_gnt_a got %b want 0", gnt_a); end
    total++; if (gnt_b !== 1'b0) begin bad++; $display("FAIL rst_gnt_b got %b want 0", gnt_b); end
    total++; if ({tl_a_o.a_valid, tl_a_o.d_ready} !== 2'b00) begin
      bad++; $display("FAIL rst_tl got %b%b want 00", tl_a_o.a_valid, tl_a_o.d_ready); end
    total++; if ({rvalid_a, err_a, busy_a} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got %b%b%b want 000", rvalid_a, err_a, busy_a); end
    total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", rdata_a); end
    tick();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_read();
    tick(); req_a = 1'b1; we = 1'b0; addr = 32'h0001_0004; smp();
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rd_gnt got %b want 1", gnt_a); end
    tick(); req_a = 1'b0; addr = '0; tl_d.a_ready = 1'b1; smp();
    total++; if (tl_a_o.a_valid !== 1'b1 || tl_a_o.a_opcode !== 3'h4 || tl_a_o.a_mask !== 4'hF ||
                 tl_a_o.a_address !== 32'h0001_0004 || tl_a_o.a_size !== 2'd2) begin
      bad++; $display("FAIL rd_achan got v=%b op=%0h m=%h a=%h s=%0d want v=1 op=4 m=f a=00010004 s=2",
        tl_a_o.a_valid, tl_a_o.a_opcode, tl_a_o.a_mask, tl_a_o.a_address, tl_a_o.a_size); end
    total++; if (tl_a_o.d_ready !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL rd_asend got dr=%b busy=%b want dr=0 busy=1", tl_a_o.d_ready, busy_a); end
    tick(); tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b1; tl_d.d_data = 32'hDEAD_BEEF; smp();
    total++; if ({tl_a_o.a_valid, tl_a_o.d_ready, rvalid_a} !== 3'b010) begin
      bad++; $display("FAIL rd_dwait got av/dr/rv=%b%b%b want 010", tl_a_o.a_valid, tl_a_o.d_ready,
        rvalid_a); end
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF || err_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL rd_resp got rv=%b d=%h e=%b b=%b want rv=1 d=deadbeef e=0 b=0",
        rvalid_a, rdata_a, err_a, busy_a); end
    tick(); smp();
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL rd_pulse got %b want 0", rvalid_a); end
  endtask

  task automatic test_write();
    tick(); req_a = 1'b1; we = 1'b1; addr = 32'h0001_0000; wdata = 32'hA5A5_0001; be = 4'hF; smp();
    tick(); req_a = 1'b0; we = 1'b0; be = '0; wdata = '0; tl_d.a_ready = 1'b1; smp();
    total++; if (tl_a_o.a_opcode !== 3'h0 || tl_a_o.a_mask !== 4'hF || tl_a_o.a_data !== 32'hA5A5_0001 ||
                 tl_a_o.a_address !== 32'h0001_0000) begin
      bad++; $display("FAIL wrf_achan got op=%0h m=%h d=%h a=%h want op=0 m=f d=a5a50001 a=00010000",
        tl_a_o.a_opcode, tl_a_o.a_mask, tl_a_o.a_data, tl_a_o.a_address); end
    tick(); tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b1; tl_d.d_data = 32'h1111_1111; smp();
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wrf_resp got rv=%b d=%h want rv=1 d=deadbeef", rvalid_a, rdata_a); end
    tick(); req_a = 1'b1; we = 1'b1; addr = 32'h0001_0002; wdata = 32'h0000_BEEF; be = 4'b0011; smp();
    tick(); req_a = 1'b0; we = 1'b0; be = '0; tl_d.a_ready = 1'b1; smp();
    total++; if (tl_a_o.a_opcode !== 3'h1 || tl_a_o.a_mask !== 4'h3 || tl_a_o.a_data !== 32'h0000_BEEF ||
                 tl_a_o.a_address !== 32'h0001_0000) begin
      bad++; $display("FAIL wrp_achan got op=%0h m=%h d=%h a=%h want op=1 m=3 d=0000beef a=00010000",
        tl_a_o.a_opcode, tl_a_o.a_mask, tl_a_o.a_data, tl_a_o.a_address); end
    tick(); tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b1; smp();
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b1 || err_a !== 1'b0) begin
      bad++; $display("FAIL wrp_resp got rv=%b e=%b want rv=1 e=0", rvalid_a, err_a); end
    tick(); req_a = 1'b1; we = 1'b1; be = 4'h0; addr = 32'h40; smp();
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL wr0_gnt got %b want 1", gnt_a); end
    tick(); req_a = 1'b0; we = 1'b0; smp();
    total++; if ({rvalid_a, err_a, tl_a_o.a_valid, busy_a} !== 4'b1000) begin
      bad++; $display("FAIL wr0_local got rv/e/av/b=%b%b%b%b want 1000", rvalid_a, err_a,
        tl_a_o.a_valid, busy_a); end
    tick(); smp();
    total++; if ({rvalid_a, tl_a_o.a_valid} !== 2'b00) begin
      bad++; $display("FAIL wr0_after got rv/av=%b%b want 00", rvalid_a, tl_a_o.a_valid); end
  endtask

  task automatic test_backpressure();
    tick(); req_a = 1'b1; we = 1'b0; addr = 32'h0002_0008; smp();
    for (int c = 1; c <= 15; c++) begin
      tick();
      req_a = 1'b0; addr = '0; tl_d = '0;
      tl_d.a_ready = (c == 6);
      if (c == 14) begin
        tl_d.d_valid = 1'b1; tl_d.d_error = 1'b1; tl_d.d_data = 32'h1234_5678;
      end
      smp();
      if (c <= 6) begin
        total++; if (tl_a_o.a_valid !== 1'b1 || tl_a_o.a_address !== 32'h0002_0008 ||
                     tl_a_o.a_opcode !== 3'h4 || tl_a_o.a_mask !== 4'hF) begin
          bad++; $display("FAIL bp_astable c=%0d got v=%b a=%h op=%0h m=%h want v=1 a=00020008 op=4 m=f",
            c, tl_a_o.a_valid, tl_a_o.a_address, tl_a_o.a_opcode, tl_a_o.a_mask); end
      end
      if (c < 15) begin
        total++; if (rvalid_a !== 1'b0) begin
          bad++; $display("FAIL bp_early c=%0d got rv=%b want 0", c, rvalid_a); end
      end else begin
        total++; if (rvalid_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h1234_5678) begin
          bad++; $display("FAIL bp_resp got rv=%b e=%b d=%h want rv=1 e=1 d=12345678",
            rvalid_a, err_a, rdata_a); end
      end
    end
  endtask

  task automatic test_foreign();
    tick(); req_a = 1'b1; we = 1'b0; addr = 32'h0000_0010; smp();
    tick(); req_a = 1'b0; tl_d.a_ready = 1'b1; smp();
    tick(); tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b1; tl_d.d_source = 8'd1;
    tl_d.d_data = 32'h0BAD_0BAD; smp();
    total++; if (tl_a_o.d_ready !== 1'b1) begin
      bad++; $display("FAIL fs_dready got %b want 1", tl_a_o.d_ready); end
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL fs_drop got rv=%b b=%b want rv=0 b=1", rvalid_a, busy_a); end
    tick(); tl_d.d_valid = 1'b1; tl_d.d_data = 32'h600D_F00D; smp();
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h600D_F00D || err_a !== 1'b0) begin
      bad++; $display("FAIL fs_resp got rv=%b d=%h e=%b want rv=1 d=600df00d e=0",
        rvalid_a, rdata_a, err_a); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 17; c++) begin
      tick();
      tl_d = '0;
      req_b = (c == 0) || (c == 8);
      we = 1'b0; addr = 32'h0000_0020;
      tl_d.a_ready = (c == 1);
      if (c == 16) begin tl_d.d_valid = 1'b1; tl_d.d_data = 32'h7777_7777; end
      smp();
      if (c == 0) begin
        total++; if (gnt_b !== 1'b1) begin bad++; $display("FAIL to_gnt got %b want 1", gnt_b); end
      end
      if (c == 6) begin
        total++; if (rvalid_b !== 1'b1 || err_b !== 1'b1 || rdata_b !== 32'h0 || busy_b !== 1'b1) begin
          bad++; $display("FAIL to_fire got rv=%b e=%b d=%h b=%b want rv=1 e=1 d=0 b=1",
            rvalid_b, err_b, rdata_b, busy_b); end
      end else if (c >= 2) begin
        total++; if (rvalid_b !== 1'b0) begin
          bad++; $display("FAIL to_quiet c=%0d got rv=%b want 0", c, rvalid_b); end
      end
      if (c == 8) begin
        total++; if (gnt_b !== 1'b0 || busy_b !== 1'b1) begin
          bad++; $display("FAIL to_drain got gnt=%b b=%b want gnt=0 b=1", gnt_b, busy_b); end
      end
      if (c == 16) begin
        total++; if (tl_b_o.d_ready !== 1'b1) begin
          bad++; $display("FAIL to_drain_dr got %b want 1", tl_b_o.d_ready); end
      end
      if (c == 17) begin
        total++; if (busy_b !== 1'b0 || tl_b_o.d_ready !== 1'b0) begin
          bad++; $display("FAIL to_idle got b=%b dr=%b want 0 0", busy_b, tl_b_o.d_ready); end
      end
    end
    for (int c = 0; c <= 7; c++) begin
      tick();
      tl_d = '0;
      req_b = (c == 0);
      tl_d.a_ready = (c == 1);
      if (c == 5) begin tl_d.d_valid = 1'b1; tl_d.d_data = 32'hCAFE_F00D; end
      smp();
      if (c == 6) begin
        total++; if (rvalid_b !== 1'b1 || err_b !== 1'b0 || rdata_b !== 32'hCAFE_F00D || busy_b !== 1'b0)
        begin
          bad++; $display("FAIL to_race got rv=%b e=%b d=%h b=%b want rv=1 e=0 d=cafef00d b=0",
            rvalid_b, err_b, rdata_b, busy_b); end
      end else if (c >= 2) begin
        total++; if (rvalid_b !== 1'b0) begin
          bad++; $display("FAIL to_race_quiet c=%0d got rv=%b want 0", c, rvalid_b); end
      end
    end
    req_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 9; c++) begin
      tick();
      req_a = (c <= 6); we = 1'b0; addr = 32'h0000_0100;
      tl_d = '0;
      tl_d.a_ready = 1'b1; tl_d.d_valid = 1'b1; tl_d.d_data = 32'h1000 + c;
      smp();
      total++; if (gnt_a !== ((c % 3 == 0) && (c <= 6))) begin
        bad++; $display("FAIL b2b_gnt c=%0d got %b want %b", c, gnt_a, (c % 3 == 0) && (c <= 6)); end
      total++; if (rvalid_a !== ((c % 3 == 0) && (c > 0))) begin
        bad++; $display("FAIL b2b_rv c=%0d got %b want %b", c, rvalid_a, (c % 3 == 0) && (c > 0)); end
      if ((c % 3 == 0) && (c > 0)) begin
        total++; if (rdata_a !== 32'h1000 + c - 1) begin
          bad++; $display("FAIL b2b_data c=%0d got %h want %h", c, rdata_a, 32'h1000 + c - 1); end
      end
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    tick(); req_a = 1'b1; we = 1'b0; addr = 32'h0000_0300; smp();
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rm_gnt0 got %b want 1", gnt_a); end
    tick(); req_a = 1'b0; rst = 1'b1; smp();
    tick(); req_a = 1'b1; smp();
    total++; if ({tl_a_o.a_valid, busy_a, rvalid_a, gnt_a} !== 4'b0000) begin
      bad++; $display("FAIL rm_asend got av/b/rv/gnt=%b%b%b%b want 0000", tl_a_o.a_valid, busy_a,
        rvalid_a, gnt_a); end
    tick(); rst = 1'b0; smp();
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rm_regnt got %b want 1", gnt_a); end
    tick(); req_a = 1'b0; tl_d.a_ready = 1'b1; smp();
    total++; if (tl_a_o.a_valid !== 1'b1) begin
      bad++; $display("FAIL rm_avalid got %b want 1", tl_a_o.a_valid); end
    tick(); tl_d.a_ready = 1'b0; rst = 1'b1; smp();
    tick(); rst = 1'b0; tl_d.d_valid = 1'b1; tl_d.d_data = 32'h99; smp();
    total++; if ({busy_a, tl_a_o.d_ready, rvalid_a} !== 3'b000) begin
      bad++; $display("FAIL rm_dwait got b/dr/rv=%b%b%b want 000", busy_a, tl_a_o.d_ready, rvalid_a); end
    tick(); tl_d = '0; smp();
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL rm_late got %b want 0", rvalid_a); end
    tick(); req_a = 1'b1; smp();
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rm_new_gnt got %b want 1", gnt_a); end
    tick(); idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_foreign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
